// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures rising-edge spacing of a tick stream and flags lock
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   enable              measurement enable; low returns the meter to IDLE
//   pulse_in            monitored tick/pulse stream
//   expected_period     target period in clk cycles
//   tolerance           allowed absolute deviation from expected_period
//   period_out          last measured period, held until the next measurement
//   period_valid        one-cycle strobe when period_out updates
//   timeout             one-cycle strobe when the counter saturates without an edge
//   lock                LOCK_N consecutive in-tolerance periods seen
//   busy                high while armed or measuring
module pulse_period_meter #(
    parameter int CNT_W   = 16,
    parameter int LOCK_N  = 4,
    parameter int SYNC_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    input  logic [CNT_W-1:0] expected_period,
    input  logic [CNT_W-1:0] tolerance,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             lock,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             lock_q, lock_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic             edge_det;
    logic [CNT_W-1:0] diff;
    logic             in_tol;
    logic [RUN_W-1:0] run_inc;

    // Input path. s3 always holds the previous sample of whatever feeds the
    // edge detector, so a level held high yields exactly one edge.
    always_comb begin
        s1_d = pulse_in;
        s2_d = s1_q;
        if (SYNC_EN != 0) begin
            s3_d     = s2_q;
            edge_det = s2_q & ~s3_q;
        end else begin
            s3_d     = pulse_in;
            edge_det = pulse_in & ~s3_q;
        end
    end

    // Tolerance check on the period about to be reported (the live counter).
    // Larger-minus-smaller keeps the difference unsigned with no wrap.
    always_comb begin
        if (counter_q > expected_period) begin
            diff = counter_q - expected_period;
        end else begin
            diff = expected_period - counter_q;
        end
        in_tol  = (diff <= tolerance);
        run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        lock_d    = lock_q;
        run_d     = run_q;

        if (!enable) begin
            state_d   = IDLE;
            counter_d = '0;
            run_d     = '0;
            lock_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    counter_d = '0;
                    state_d   = ARM;
                end
                ARM: begin
                    // First edge only starts the count; nothing to report yet.
                    if (edge_det) begin
                        counter_d = CNT_W'(1);
                        state_d   = MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge on the saturation cycle still reports normally.
                    if (edge_det) begin
                        period_d  = counter_q;
                        valid_d   = 1'b1;
                        counter_d = CNT_W'(1);
                        if (in_tol) begin
                            run_d  = run_inc;
                            lock_d = (run_inc == RUN_MAX);
                        end else begin
                            run_d  = '0;
                            lock_d = 1'b0;
                        end
                    end else if (counter_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        lock_d    = 1'b0;
                        run_d     = '0;
                        counter_d = '0;
                        state_d   = ARM;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    counter_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            counter_q <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            lock_q    <= 1'b0;
            run_q     <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            counter_q <= counter_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            lock_q    <= lock_d;
            run_q     <= run_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign lock         = lock_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - directed self-checking bench for pulse_period_meter
module tb_pulse_period_meter;

    logic        clk;
    logic        reset;

    // dut_a: synchronized input, 16-bit counter
    logic        enable_a, pulse_a;
    logic [15:0] exp_a, tol_a, period_a;
    logic        valid_a, timeout_a, lock_a, busy_a;

    // dut_b: unsynchronized input, 8-bit counter
    logic        enable_b, pulse_b;
    logic [7:0]  exp_b, tol_b, period_b;
    logic        valid_b, timeout_b, lock_b, busy_b;

    int          tests_run;
    int          tests_failed;

    int          nv;
    logic [15:0] pv;
    logic        lk;
    logic        bz;
    int          nt;
    logic [7:0]  pvb;

    pulse_period_meter #(.CNT_W(16), .LOCK_N(4), .SYNC_EN(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .pulse_in(pulse_a),
        .expected_period(exp_a), .tolerance(tol_a), .period_out(period_a),
        .period_valid(valid_a), .timeout(timeout_a), .lock(lock_a), .busy(busy_a)
    );

    pulse_period_meter #(.CNT_W(8), .LOCK_N(4), .SYNC_EN(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .pulse_in(pulse_b),
        .expected_period(exp_b), .tolerance(tol_b), .period_out(period_b),
        .period_valid(valid_b), .timeout(timeout_b), .lock(lock_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One window on dut_a: tick in the first cycle, low for n-1 cycles.
    // A strobe seen in a window reports the length of the previous window.
    task automatic tick_a(input int n);
        nv = 0; pv = '0; lk = 1'b0; bz = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid_a) begin nv++; pv = period_a; lk = lock_a; end
            if (!busy_a) bz = 1'b0;
            pulse_a = (i == 0);
        end
    endtask

    task automatic tick_b(input int n);
        nv = 0; pvb = '0; nt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid_b) begin nv++; pvb = period_b; end
            if (timeout_b) nt++;
            pulse_b = (i == 0);
        end
    endtask

    task automatic test_reset;
        tests_run++; if (period_a !== 16'd0 || valid_a !== 1'b0 || timeout_a !== 1'b0 || lock_a !== 1'b0 || busy_a !== 1'b0) begin
            tests_failed++; $display("FAIL reset_a got p=%0d v=%b t=%b l=%b b=%b want all 0", period_a, valid_a, timeout_a, lock_a, busy_a); end
        tests_run++; if (period_b !== 8'd0 || valid_b !== 1'b0 || timeout_b !== 1'b0 || lock_b !== 1'b0 || busy_b !== 1'b0) begin
            tests_failed++; $display("FAIL reset_b got p=%0d v=%b t=%b l=%b b=%b want all 0", period_b, valid_b, timeout_b, lock_b, busy_b); end
    endtask

    task automatic test_basic;
        exp_a = 16'd10; tol_a = 16'd0; enable_a = 1'b1;
        repeat (3) @(negedge clk);
        tick_a(10);
        tests_run++; if (nv !== 0) begin tests_failed++; $display("FAIL basic_first_edge got %0d strobes want 0", nv); end
        for (int k = 2; k <= 5; k++) begin
            tick_a(10);
            tests_run++; if (nv !== 1 || pv !== 16'd10) begin
                tests_failed++; $display("FAIL basic_period k=%0d got n=%0d p=%0d want n=1 p=10", k, nv, pv); end
            tests_run++; if (lk !== (k == 5)) begin
                tests_failed++; $display("FAIL basic_lock k=%0d got %b want %b", k, lk, (k == 5)); end
            tests_run++; if (bz !== 1'b1) begin tests_failed++; $display("FAIL basic_busy k=%0d got %b want 1", k, bz); end
        end
    endtask

    task automatic test_lock_break;
        tol_a = 16'd1;
        tick_a(12);
        tests_run++; if (pv !== 16'd10 || lk !== 1'b1) begin
            tests_failed++; $display("FAIL break_pre got p=%0d l=%b want p=10 l=1", pv, lk); end
        tick_a(10);
        tests_run++; if (nv !== 1 || pv !== 16'd12 || lk !== 1'b0) begin
            tests_failed++; $display("FAIL break_gap got n=%0d p=%0d l=%b want n=1 p=12 l=0", nv, pv, lk); end
        for (int k = 1; k <= 4; k++) begin
            tick_a(10);
            tests_run++; if (pv !== 16'd10 || lk !== (k == 4)) begin
                tests_failed++; $display("FAIL relock k=%0d got p=%0d l=%b want p=10 l=%b", k, pv, lk, (k == 4)); end
        end
    endtask

    task automatic test_tolerance;
        int  len [7];
        int  rep [7];
        bit  lkx [7];
        len = '{13, 8, 12, 9, 11, 13, 10};
        rep = '{10, 13, 8, 12, 9, 11, 13};
        lkx = '{1, 0, 0, 0, 0, 1, 0};
        tol_a = 16'd2;
        for (int j = 0; j < 7; j++) begin
            tick_a(len[j]);
            tests_run++; if (nv !== 1 || pv !== 16'(rep[j]) || lk !== lkx[j]) begin
                tests_failed++; $display("FAIL tol j=%0d got n=%0d p=%0d l=%b want n=1 p=%0d l=%b", j, nv, pv, lk, rep[j], lkx[j]); end
        end
    endtask

    task automatic test_enable_drop;
        for (int k = 1; k <= 5; k++) tick_a(10);
        tests_run++; if (lk !== 1'b1) begin tests_failed++; $display("FAIL drop_prelock got %b want 1", lk); end
        enable_a = 1'b0;
        @(negedge clk);
        tests_run++; if (busy_a !== 1'b0 || lock_a !== 1'b0 || period_a !== 16'd10 || valid_a !== 1'b0 || timeout_a !== 1'b0) begin
            tests_failed++; $display("FAIL drop_idle got b=%b l=%b p=%0d v=%b t=%b want b=0 l=0 p=10 v=0 t=0", busy_a, lock_a, period_a, valid_a, timeout_a); end
        enable_a = 1'b1;
        tick_a(10);
        tests_run++; if (nv !== 0) begin tests_failed++; $display("FAIL drop_rearm_first got %0d strobes want 0", nv); end
        tick_a(10);
        tests_run++; if (nv !== 1 || pv !== 16'd10) begin
            tests_failed++; $display("FAIL drop_rearm_second got n=%0d p=%0d want n=1 p=10", nv, pv); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++; if (period_a !== 16'd0 || busy_a !== 1'b0 || lock_a !== 1'b0 || valid_a !== 1'b0 || timeout_a !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid got p=%0d b=%b l=%b v=%b t=%b want all 0", period_a, busy_a, lock_a, valid_a, timeout_a); end
        @(negedge clk);
        reset = 1'b0;
        tick_a(10);
        tests_run++; if (nv !== 0) begin tests_failed++; $display("FAIL reset_rearm_first got %0d strobes want 0", nv); end
        tick_a(10);
        tests_run++; if (nv !== 1 || pv !== 16'd10) begin
            tests_failed++; $display("FAIL reset_rearm_second got n=%0d p=%0d want n=1 p=10", nv, pv); end
    endtask

    task automatic test_timeout;
        int first_to, n_to, n_v;
        exp_b = 8'd2; tol_b = 8'd0; enable_b = 1'b1;
        @(negedge clk);
        first_to = -1; n_to = 0; n_v = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (timeout_b) begin n_to++; if (first_to < 0) first_to = i; end
            if (valid_b) n_v++;
            pulse_b = (i == 0);
        end
        tests_run++; if (first_to !== 256 || n_to !== 1) begin
            tests_failed++; $display("FAIL timeout_cycle got first=%0d count=%0d want first=256 count=1", first_to, n_to); end
        tests_run++; if (n_v !== 0 || period_b !== 8'd0) begin
            tests_failed++; $display("FAIL timeout_noreport got strobes=%0d p=%0d want 0 0", n_v, period_b); end
        tests_run++; if (busy_b !== 1'b1) begin tests_failed++; $display("FAIL timeout_arm busy got %b want 1", busy_b); end
        tick_b(5);
        tests_run++; if (nv !== 0 || nt !== 0) begin tests_failed++; $display("FAIL timeout_next got n=%0d t=%0d want 0 0", nv, nt); end
        tick_b(5);
        tests_run++; if (nv !== 1 || pvb !== 8'd5) begin tests_failed++; $display("FAIL timeout_after got n=%0d p=%0d want n=1 p=5", nv, pvb); end
    endtask

    task automatic test_min_level;
        int n_hi;
        tick_b(2);
        for (int k = 0; k < 3; k++) begin
            tick_b(2);
            tests_run++; if (nv !== 1 || pvb !== 8'd2) begin
                tests_failed++; $display("FAIL min_period k=%0d got n=%0d p=%0d want n=1 p=2", k, nv, pvb); end
        end
        n_hi = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid_b) n_hi++;
            pulse_b = (i < 20);
        end
        tests_run++; if (n_hi !== 1) begin tests_failed++; $display("FAIL level_single got %0d strobes want 1", n_hi); end
        tick_b(5);
        tests_run++; if (nv !== 1 || pvb !== 8'd25) begin
            tests_failed++; $display("FAIL level_period got n=%0d p=%0d want n=1 p=25", nv, pvb); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset = 1'b1;
        enable_a = 1'b0; pulse_a = 1'b0; exp_a = '0; tol_a = '0;
        enable_b = 1'b0; pulse_b = 1'b0; exp_b = '0; tol_b = '0;
        repeat (3) @(negedge clk);
        test_reset;
        reset = 1'b0;
        test_basic;
        test_lock_break;
        test_tolerance;
        test_enable_drop;
        test_timeout;
        test_min_level;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Measures the spacing between rising edges of a pulse/tick stream, such as the single-cycle divided tick produced by the clock divider. It reports each measured period in clk cycles. It asserts a lock flag once a run of consecutive periods matches an expected value within tolerance. It sits on the receive side of tick/divided-clock generation, for self-check and bring-up monitoring.

Parameters:
CNT_W, 16, width of period counter and period_out
LOCK_N, 4, consecutive in-tolerance periods required to assert lock
SYNC_EN, 1, 1 = pulse_in passes through a 2-flop synchronizer; 0 = pulse_in is treated as synchronous to clk

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  measurement enable; low forces IDLE
pulse_in  input  1  monitored tick/pulse stream
expected_period  input  CNT_W  target period in clk cycles
tolerance  input  CNT_W  allowed absolute deviation from expected_period
period_out  output  CNT_W  last measured period, held until next measurement
period_valid  output  1  one-cycle strobe when period_out updates
timeout  output  1  one-cycle strobe when counter saturates without an edge
lock  output  1  level; LOCK_N consecutive in-tolerance periods seen
busy  output  1  high in ARM or MEASURE

Behaviour:
- One clock: clk. Reset is asynchronous and active-high.
- Reset values: period_out=0, period_valid=0, timeout=0, lock=0, busy=0, counter=0, lock run count=0, state=IDLE, synchronizer/edge flops=0.
- Input path, SYNC_EN=1: s1<=pulse_in, s2<=s1, s3<=s2; edge = s2 & ~s3. This adds 2 cycles of latency before edge detection.
- Input path, SYNC_EN=0: s3<=pulse_in; edge = pulse_in & ~s3.
- A level held high produces a single edge. pulse_in must be low for at least 1 cycle between edges.
- IDLE:
  - busy=0, counter held at 0.
  - enable=1 -> ARM.
- ARM:
  - busy=1.
  - Waits for the first edge. On edge: counter<=1 -> MEASURE.
  - No period is reported for the first edge.
- MEASURE:
  - Counter increments every cycle.
  - On edge: period_out<=counter, period_valid=1 next cycle, counter<=1, stay in MEASURE.
  - Resulting period: edges N cycles apart report exactly N. Minimum reportable period is 2.
- Saturation:
  - If counter == 2^CNT_W-1 and no edge occurs that cycle: timeout strobe for 1 cycle, lock<=0, run count<=0, counter<=0 -> ARM.
  - period_out is unchanged and period_valid is not asserted.
  - If an edge coincides with saturation, the edge wins: the value is reported normally and there is no timeout.
- Lock evaluation, on each reported period P:
  - In tolerance when |P - expected_period| <= tolerance. Use unsigned compare on the larger-minus-smaller difference (no wrap).
  - In tolerance: run count increments, saturating at LOCK_N. lock<=1 in the same cycle period_valid asserts once run count reaches LOCK_N.
  - Out of tolerance: run count<=0, lock<=0 in the same cycle as period_valid.
  - Changes to expected_period or tolerance take effect at the next reported period only.
- enable deasserted in any state:
  - Next cycle -> IDLE, counter<=0, run count<=0, lock<=0. No strobe.
  - period_out holds its last value.
  - An edge in the same cycle enable falls is ignored.
- reset mid-measurement: all state returns to reset values immediately (asynchronous). The next measurement restarts from ARM once reset is released and enable=1.
- Strobes period_valid and timeout are never high in the same cycle.

Test Plan:
- SYNC_EN=1, CNT_W=16, enable=1, pulse_in = 1-cycle tick every 10 clk, expected_period=10, tolerance=0 -> first strobe on the second tick with period_out=10; lock=1 on the 4th period_valid; busy=1 throughout.
- Lock break: locked on a 10-cycle tick stream, insert one 12-cycle gap with tolerance=1 -> period_out=12, lock drops on that strobe. Relock after 4 more 10-cycle periods.
- Tolerance: expected_period=10, tolerance=2, periods 8, 12, 9, 11 -> all in tolerance, lock=1 after the 4th. Period 13 -> lock=0.
- Timeout: CNT_W=8, pulse_in stops after one edge -> timeout strobe when the counter reaches 255, period_valid stays 0, state returns to ARM. Next edge gives no report; the edge after it reports its period.
- Minimum/level: SYNC_EN=0, pulse_in toggling every cycle -> period_out=2 each strobe. pulse_in held high for 20 cycles -> no report until after it falls and rises again.
- Control: enable dropped mid-MEASURE, then reset asserted mid-MEASURE -> IDLE, lock=0, busy=0 with period_out held under enable drop; all outputs 0 asynchronously under reset. Re-enable: first report only after two edges.
